// File: rtl/instruction_dispatcher.sv
// Queues 24-bit instructions, issues them one at a time to a fixed-latency processor
// and holds each captured result until accepted. Optional opcode check: ILLEGAL_OP_CHECK_EN.
module instruction_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  output logic [7:0]  opcode,
  output logic [7:0]  operand1,
  output logic [7:0]  operand2,
  input  logic [7:0]  proc_result,
  input  logic [7:0]  proc_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_result,
  output logic [7:0]  out_flags,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    wait_cnt;
  state_t        state;
  logic          push;
  logic          pop;
  logic [23:0]   head;
  logic          illegal_head;

  // Ready depends only on registered occupancy, so a full queue refuses even when a pop is due.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == ISSUE);
  assign head     = mem[rd_ptr];

`ifdef ILLEGAL_OP_CHECK_EN
  assign illegal_head = (head[23:16] >= 8'h10);
`else
  assign illegal_head = 1'b0;
`endif

  // NOTE: storage carries no reset; occupancy is tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      opcode     <= 8'h00;
      operand1   <= 8'h00;
      operand2   <= 8'h00;
      out_valid  <= 1'b0;
      out_result <= 8'h00;
      out_flags  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != '0) state <= ISSUE;
        end
        ISSUE: begin
          if (illegal_head) begin
            // Dropped entry: carry on with whatever remains after this pop.
            state <= ((count > CW'(1)) || push) ? ISSUE : IDLE;
          end else begin
            opcode   <= head[23:16];
            operand1 <= head[15:8];
            operand2 <= head[7:0];
            wait_cnt <= 3'(LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            out_result <= proc_result;
            out_flags  <= proc_flags;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= (count != '0) ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ILLEGAL_OP_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= pop && illegal_head;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: scoreboard of accepted instructions plus a
// fixed-latency processor model; directed scenarios with literal expectations.
module tb_instruction_dispatcher;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic [7:0]  opcode;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [7:0]  proc_result;
  logic [7:0]  proc_flags;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_result;
  logic [7:0]  out_flags;
  logic        err;

  instruction_dispatcher #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .proc_result(proc_result), .proc_flags(proc_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .err(err)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  int err_cycles = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_head;
  logic [15:0] mon_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor behaviour: {flags, result}; flags = result ^ opcode.
  function automatic logic [15:0] proc_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      8'h01:   r = a + b;
      8'h02:   r = a - b;
      8'h03:   r = a & b;
      default: r = a ^ b;
    endcase
    return {r ^ op, r};
  endfunction

  function automatic bit is_legal(input logic [7:0] op);
`ifdef ILLEGAL_OP_CHECK_EN
    return op < 8'h10;
`else
    return (op == op);
`endif
  endfunction

  // Result appears LATENCY edges after the operands change.
  logic [15:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= proc_fn(opcode, operand1, operand2);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign proc_result = pipe[LATENCY-1][7:0];
  assign proc_flags  = pipe[LATENCY-1][15:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the scoreboard head; pushes recorded as they will occur.
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) begin
        check("pending_on_out_valid", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_head = exp_q[0];
          mon_exp  = proc_fn(mon_head[23:16], mon_head[15:8], mon_head[7:0]);
          check("out_result", {24'h0, out_result}, {24'h0, mon_exp[7:0]});
          check("out_flags", {24'h0, out_flags}, {24'h0, mon_exp[15:8]});
          check("operands_held", {8'h0, opcode, operand1, operand2}, {8'h0, mon_head});
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_done++;
          end
        end
      end
`ifdef ILLEGAL_OP_CHECK_EN
      if (err) err_cycles++;
`else
      check("err_tied_low", {31'h0, err}, 32'd0);
`endif
      if (in_valid && in_ready && is_legal(in_instr[23:16])) exp_q.push_back(in_instr);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] ins);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    check("push_accept", {31'h0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      step();
      t++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  logic [23:0] t2_instrs [5] = '{24'h020903, 24'h030F3C, 24'h011122, 24'h04AA55, 24'h021020};
  logic [23:0] t3_instrs [9] = '{24'h010101, 24'h020503, 24'h03F00F, 24'h057788, 24'h011010,
                                 24'h02FF01, 24'h0633CC, 24'h030101, 24'h018080};

  initial begin
    int base;
    int t;
    logic [7:0]  hold_res;
    logic [7:0]  hold_flg;
    logic [23:0] hold_ops;

    reset = 1'b0; in_valid = 1'b0; in_instr = 24'h0; out_ready = 1'b1;
    step(2);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_operands", {8'h0, opcode, operand1, operand2}, 32'h0);
    check("rst_outputs", {16'h0, out_result, out_flags}, 32'h0);
    reset = 1'b1;

    // Single instruction: issue on the second edge after the push, capture LATENCY+1 edges later.
    in_valid = 1'b1; in_instr = 24'h010503;
    check("t1_in_ready", {31'h0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("t1_no_issue_push_edge", {24'h0, opcode}, 32'h0);
    step();
    check("t1_no_issue_idle_edge", {24'h0, opcode}, 32'h0);
    step();
    check("t1_issue_operands", {8'h0, opcode, operand1, operand2}, 32'h010503);
    for (int k = 1; k <= LATENCY + 1; k++) begin
      step();
      check("t1_out_valid_timing", {31'h0, out_valid}, 32'(k == LATENCY + 1));
    end
    check("t1_out_result", {24'h0, out_result}, 32'h08);
    check("t1_out_flags", {24'h0, out_flags}, 32'h09);
    step();
    check("t1_accept_clears", {31'h0, out_valid}, 32'd0);

    // Fill the queue behind a stalled result, hold for 10 cycles, then drain in order.
    out_ready = 1'b0;
    base = n_done;
    for (int i = 0; i < 5; i++) push(t2_instrs[i]);
    check("t2_full_in_ready", {31'h0, in_ready}, 32'd0);
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    check("t2_out_valid", {31'h0, out_valid}, 32'd1);
    check("t2_first_result", {24'h0, out_result}, 32'h06);
    hold_res = out_result;
    hold_flg = out_flags;
    hold_ops = {opcode, operand1, operand2};
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_result", {16'h0, out_result, out_flags}, {16'h0, hold_res, hold_flg});
      check("t2_hold_operands", {8'h0, opcode, operand1, operand2}, {8'h0, hold_ops});
      check("t2_hold_valid", {31'h0, out_valid}, 32'd1);
      check("t2_hold_no_pop", {31'h0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    wait_drain(300);
    check("t2_done_count", n_done - base, 32'd5);

    // Push coinciding with the issue pop at count 2; nine pushes wrap the pointers.
    out_ready = 1'b0;
    base = n_done;
    for (int i = 0; i < 3; i++) push(t3_instrs[i]);
    check("t3_count_simul", 32'(dut.count), 32'd2);
    out_ready = 1'b1;
    for (int i = 3; i < 9; i++) push(t3_instrs[i]);
    wait_drain(400);
    check("t3_done_count", n_done - base, 32'd9);

    // Reset during WAIT with three queued discards everything.
    out_ready = 1'b0;
    push(24'h010203);
    push(24'h020304);
    push(24'h030405);
    push(24'h040506);
    check("t4_count_before_reset", 32'(dut.count), 32'd3);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t4_out_valid", {31'h0, out_valid}, 32'd0);
    check("t4_in_ready", {31'h0, in_ready}, 32'd1);
    check("t4_operands", {8'h0, opcode, operand1, operand2}, 32'h0);
    check("t4_outputs", {16'h0, out_result, out_flags}, 32'h0);
    check("t4_err", {31'h0, err}, 32'd0);
    step(2);
    reset = 1'b1;
    base = n_done;
    in_valid = 1'b1; in_instr = 24'h012030;
    step();
    in_valid = 1'b0;
    check("t4_no_issue_edge1", {24'h0, opcode}, 32'h0);
    step();
    check("t4_no_issue_edge2", {24'h0, opcode}, 32'h0);
    step();
    check("t4_issue_after_reset", {8'h0, opcode, operand1, operand2}, 32'h012030);
    out_ready = 1'b1;
    wait_drain(100);
    check("t4_done_count", n_done - base, 32'd1);

`ifdef ILLEGAL_OP_CHECK_EN
    // Illegal head is dropped with one err pulse; only the legal one completes.
    base = n_done;
    err_cycles = 0;
    push(24'h200102);
    push(24'h020703);
    wait_drain(100);
    step(2);
    check("t5_err_pulses", err_cycles, 32'd1);
    check("t5_done_count", n_done - base, 32'd1);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from operand drive to valid proc_result; legal range 1..7.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host offers an instruction.
REQ-006 in_ready  output  1  queue can accept an instruction.
REQ-007 in_instr  input  24  {opcode[23:16], operand1[15:8], operand2[7:0]}.
REQ-008 opcode  output  8  opcode driven to the downstream processor.
REQ-009 operand1  output  8  first operand driven to the processor.
REQ-010 operand2  output  8  second operand driven to the processor.
REQ-011 proc_result  input  8  processor result.
REQ-012 proc_flags  input  8  processor flags.
REQ-013 out_valid  output  1  captured result available.
REQ-014 out_ready  input  1  consumer accepts the captured result.
REQ-015 out_result  output  8  captured result.
REQ-016 out_flags  output  8  captured flags.
REQ-017 err  output  1  one-cycle illegal-opcode pulse; tied 0 when the check is compiled out.

Function
REQ-018 SHALL buffer instructions in a DEPTH-entry FIFO; push when in_valid and in_ready are both 1 at a clock edge.
REQ-019 in_ready SHALL equal (count < DEPTH) from registered state; a push into a full queue SHALL never occur.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL run FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE -> ISSUE when count > 0; IDLE SHALL remain IDLE when count = 0.
REQ-023 ISSUE (1 cycle) SHALL pop the head entry and register it onto opcode/operand1/operand2; next state WAIT with a wait counter loaded to LATENCY.
REQ-024 opcode/operand1/operand2 SHALL hold stable from ISSUE until the next ISSUE.
REQ-025 WAIT SHALL decrement the counter each cycle; at zero it SHALL capture proc_result/proc_flags into out_result/out_flags, set out_valid, and go to HOLD.
REQ-026 Capture SHALL occur exactly LATENCY+1 edges after the ISSUE edge.
REQ-027 HOLD SHALL keep out_valid=1 and out_result/out_flags stable until out_ready=1; on acceptance, next state SHALL be ISSUE if count > 0, else IDLE, with out_valid cleared.
REQ-028 out_valid asserted together with out_ready already high SHALL complete in one HOLD cycle; only one instruction SHALL be in flight at a time.

Reset
REQ-029 While reset=0: FIFO empty, pointers/count 0, FSM IDLE, in_ready=1, out_valid=0, err=0, and opcode/operand1/operand2/out_result/out_flags = 8'h00.
REQ-030 Reset asserted mid-operation SHALL discard queued and in-flight instructions; the first issue after release SHALL occur no earlier than the second edge after reset deasserts.

Configuration
REQ-031 With ILLEGAL_OP_CHECK_EN defined, an ISSUE head whose opcode >= 8'h10 SHALL be popped but not driven to the processor; err SHALL pulse for 1 cycle; the FSM SHALL return to ISSUE/IDLE with no out_valid.
REQ-032 Without ILLEGAL_OP_CHECK_EN, every opcode SHALL be issued normally and err SHALL be constant 0.

Verification
REQ-033 Bench SHALL push {8'h01,8'h05,8'h03} with processor model result=8'h08 and out_ready=1 -> out_valid exactly LATENCY+1 edges after ISSUE with out_result=8'h08.
REQ-034 Bench SHALL push 5 instructions with out_ready=0 and DEPTH=4 -> in_ready=0 after the queue fills; all 5 complete in order once out_ready=1.
REQ-035 Bench SHALL hold out_ready=0 for 10 cycles in HOLD -> out_result/out_flags and opcode stay constant; no further pop occurs.
REQ-036 Bench SHALL push and pop simultaneously at count=2 -> count stays 2; pointer wrap after 9 pushes preserves order.
REQ-037 Bench SHALL assert reset=0 during WAIT with 3 queued -> out_valid=0, in_ready=1, and outputs 8'h00 immediately.
REQ-038 With ILLEGAL_OP_CHECK_EN, bench SHALL push opcode 8'h20 then 8'h02 -> one err pulse, a single out_valid for 8'h02 only.
